// File: rtl/gfx_defs.sv
// Shared raster definitions: tile size, coordinate width, fragment and lane-index types.
`ifndef GFX_RASTER_SIZE
`define GFX_RASTER_SIZE 4
`endif
`ifndef GFX_RASTER_BITS
`define GFX_RASTER_BITS 8
`endif

package gfx_defs;
  localparam int RASTER_SIZE  = `GFX_RASTER_SIZE;
  localparam int RASTER_LANES = RASTER_SIZE * RASTER_SIZE;

  typedef struct packed {
    logic [`GFX_RASTER_BITS-1:0] y;
    logic [`GFX_RASTER_BITS-1:0] x;
  } frag_xy;

  typedef logic [$clog2(RASTER_LANES)-1:0] raster_lane_idx;

  typedef enum logic {ST_IDLE, ST_DRAIN} funnel_state_e;
endpackage

// File: rtl/gfx_raster_funnel_pick.sv
// Lowest-set-bit priority encoder over the pending-lane mask, plus any / exactly-one flags.
module gfx_raster_funnel_pick #(
  parameter  int LANES = 16,
  localparam int IW    = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic [LANES-1:0] mask,
  output logic [IW-1:0]    index,
  output logic             any,
  output logic             onehot_single
);
  always_comb begin
    index = '0;
    for (int i = LANES - 1; i >= 0; i--)
      if (mask[i]) index = IW'(i);
  end

  assign any           = |mask;
  assign onehot_single = any && ((mask & (mask - LANES'(1))) == '0);
endmodule

// File: rtl/gfx_raster_funnel.sv
// Serializes painted fine-raster lanes into one valid/ready fragment stream, lowest lane first.
// Optional counters enabled by defining GFX_RASTER_FUNNEL_STATS_EN.
module gfx_raster_funnel
  import gfx_defs::*;
#(
  parameter  int SIZE  = `GFX_RASTER_SIZE,
  localparam int LANES = SIZE * SIZE,
  localparam int LW    = $clog2(LANES)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  frag_xy [LANES-1:0]     in_frag,
  input  logic   [LANES-1:0]     in_paint,
  output logic                   stall,
  output logic                   out_valid,
  input  logic                   out_ready,
  output frag_xy                 out_frag,
  output logic   [LW-1:0]        out_lane,
  output logic                   out_last
`ifdef GFX_RASTER_FUNNEL_STATS_EN
  ,
  input  logic                   stats_clear,
  output logic   [31:0]          stat_frags,
  output logic   [31:0]          stat_batches
`endif
);
  funnel_state_e         state_q, state_d;
  logic   [LANES-1:0]    mask_q, mask_d;
  frag_xy [LANES-1:0]    held_q;
  logic   [LW-1:0]       pick_idx;
  logic                  pick_any, pick_single;
  logic                  drain, accept, capture;

  gfx_raster_funnel_pick #(.LANES(LANES)) u_pick (
    .mask          (mask_q),
    .index         (pick_idx),
    .any           (pick_any),
    .onehot_single (pick_single)
  );

  assign drain     = (state_q == ST_DRAIN);
  assign out_valid = drain && pick_any;
  assign out_lane  = pick_idx;
  assign out_frag  = held_q[pick_idx];
  assign out_last  = drain && pick_single;
  // Only combinational input->output path: releasing stall on the final accepted beat.
  assign stall     = drain && !(out_ready && out_last);

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    capture = 1'b0;
    accept  = out_valid && out_ready;
    if (accept) begin
      mask_d = mask_q & ~(LANES'(1) << pick_idx);
      if (out_last) state_d = ST_IDLE;
    end
    // Capture when idle, or on the edge the last beat leaves (no bubble between batches).
    if (in_valid && (|in_paint) && (!drain || (accept && out_last))) begin
      capture = 1'b1;
      mask_d  = in_paint;
      state_d = ST_DRAIN;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      mask_q  <= '0;
      held_q  <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      if (capture) held_q <= in_frag;
    end
  end

`ifdef GFX_RASTER_FUNNEL_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_frags   <= '0;
      stat_batches <= '0;
    end else if (stats_clear) begin
      stat_frags   <= '0;
      stat_batches <= '0;
    end else begin
      if (accept)  stat_frags   <= stat_frags + 32'd1;
      if (capture) stat_batches <= stat_batches + 32'd1;
    end
  end
`endif
endmodule
